pipelined_segment_adder: RTL
============================

Name: pipelined_segment_adder

Overview:
- Parametrised, pipelined successor to the fixed 32-bit two-segment ripple adder.
- Splits a WIDTH-bit add/subtract into SEG_WIDTH-bit segments. One segment is resolved per pipeline stage, with the carry registered between stages.
- Produces the LEGv8 NZCV flags and uses a valid/ready handshake.
- Sits between the ALU operand muxes and the execute/writeback register. Used for 64-bit datapath adds, SUBS/ADDS and address generation.

Parameters:
- WIDTH, 64, operand/result width. Must be an integer multiple of SEG_WIDTH; any other value is an elaboration error.
- SEG_WIDTH, 16, segment width resolved per stage.
- STAGES, WIDTH/SEG_WIDTH (derived, local), pipeline depth and latency in advancing cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block accepts operands this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B (computed as A + ~B + 1)
- c_in  in  1  carry-in for add mode only; ignored when sub=1
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- flag_n, flag_z, flag_c, flag_v  out  1 each  negative, zero, carry, signed overflow

Behaviour:
- Stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
  - When advance=0, every stage register, including valid bits, holds its value.
- Stage structure:
  - Stage s (0..STAGES-1) adds segment s of A and B', where B' = sub ? ~b_in : b_in.
  - The carry into stage 0 is sub ? 1 : c_in. Stage s>0 takes the registered carry from stage s-1.
  - Upper operand segments are delay-registered (skewed) so segment s reaches stage s alongside its carry.
  - Lower result segments are delay-registered so the full result emerges together.
- Latency:
  - An operand accepted on edge k appears with out_valid=1 after STAGES advancing edges.
  - With defaults, accept at edge k gives out_valid from edge k+4, provided there are no stalls in between.
  - Throughput is one result per cycle when out_ready=1.
- Stage valids:
  - Each stage carries a valid bit. A bubble (in_valid=0 on an advancing edge) propagates as valid=0.
  - Bubbles are not squeezed out: the pipeline shifts as a whole.
- Flags, computed from the final stage and registered with sum:
  - N = sum[WIDTH-1].
  - Z = (sum == 0).
  - C = carry out of the MSB. For subtract this means "no borrow", so C=1 when A>=B unsigned.
  - V = carry-into-MSB XOR carry-out-of-MSB.
- Width rules: all arithmetic is modulo 2^WIDTH. The final carry goes only to flag_c. No internal segment carry is visible.
- Output stability: while out_valid=1 and out_ready=0, sum and all flags are held stable.
- Reset:
  - Takes priority over everything on any edge, including mid-stall and with in-flight data.
  - All stage valids clear to 0, so in-flight operations are discarded. sum=0, all flags=0, out_valid=0, all internal carries=0.
  - In the cycle after reset deassertion, in_ready=1.
- Simultaneous events:
  - A transfer-out and a transfer-in on the same edge are legal; both take effect.
  - A new operand entering stage 0 never disturbs data in later stages.
- Operand sampling: inputs are sampled only on a transfer-in edge. Changing a_in/b_in/sub while in_ready=0 has no effect.

Test Plan:
- Latency and add, defaults:
  - Stimulus: after reset, send one beat A=64'h0000_0000_FFFF_FFFF, B=1, sub=0, c_in=0, with out_ready=1.
  - Required: out_valid exactly 4 edges later; sum=64'h0000_0001_0000_0000; NZCV=0000. The carry crosses segments 1→2 correctly.
- Subtract flags:
  - A=5, B=5, sub=1 gives sum=0, Z=1, C=1, N=0, V=0.
  - A=3, B=5, sub=1 gives sum=64'hFFFF_FFFF_FFFF_FFFE, N=1, C=0.
  - A=64'h8000_0000_0000_0000, B=1, sub=1 gives V=1, C=1.
- Full-carry ripple and wrap:
  - A=all-ones, B=0, c_in=1 gives sum=0, Z=1, C=1, V=0.
  - A=64'h7FFF_FFFF_FFFF_FFFF, B=1 gives N=1, V=1.
- Back-to-back and backpressure:
  - Stream 8 beats (A=i, B=100·i) with out_ready toggling 1,0,0,1,...
  - Required: all 8 results appear in order with no loss or duplication. in_ready=0 exactly when out_valid=1 and out_ready=0. Outputs stay stable while stalled.
- Bubbles: alternate in_valid 1/0 for 6 cycles. Required: out_valid shows the same 1/0 pattern, delayed by 4 cycles.
- Reset mid-flight and parameter variants:
  - Assert reset for one cycle with 3 beats in flight. Required: no output is ever produced for those beats; out_valid=0 and sum=0 after the reset edge.
  - Rerun the first scenario with WIDTH=32/SEG_WIDTH=16 (latency 2) and WIDTH=64/SEG_WIDTH=64 (latency 1).

Source files
------------

// File: rtl/pipelined_segment_adder_if.sv
// Operand/result handshake bundle for pipelined_segment_adder.
// master drives operands and result-ready; slave is the adder side.
interface pipelined_segment_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a_in, b_in, sub, c_in, out_ready,
    input  in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a_in, b_in, sub, c_in, out_ready,
    output in_ready, out_valid, sum, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/pipelined_segment_adder.sv
// Pipelined WIDTH-bit add/subtract resolving one SEG_WIDTH segment per stage,
// with LEGv8 NZCV flags and a whole-pipeline valid/ready stall.
module pipelined_segment_adder #(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pipelined_segment_adder_if.slave bus
);
  localparam int STAGES = WIDTH / SEG_WIDTH;

  if ((SEG_WIDTH < 1) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_width_check
    $error("pipelined_segment_adder: WIDTH must be a positive multiple of SEG_WIDTH");
  end

  // Index s holds the operands, carry-in and lower partial sum entering stage s.
  logic [STAGES-1:0]  r_valid;
  logic [STAGES-1:0]  r_carry;
  logic [WIDTH-1:0]   r_a    [STAGES];
  logic [WIDTH-1:0]   r_b    [STAGES];
  logic [WIDTH-1:0]   r_psum [STAGES];

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_flag_n;
  logic               r_flag_z;
  logic               r_flag_c;
  logic               r_flag_v;

  logic               w_advance;
  logic [WIDTH-1:0]   w_b_eff;
  logic [SEG_WIDTH:0] w_seg_add   [STAGES];
  logic [WIDTH-1:0]   w_psum_next [STAGES];
  logic [WIDTH-1:0]   w_result;
  logic               w_carry_out;
  logic               w_carry_msb;

  assign w_advance    = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;
  assign w_b_eff      = bus.sub ? ~bus.b_in : bus.b_in;

  always_comb begin
    for (int unsigned s = 0; s < STAGES; s++) begin
      w_seg_add[s] = {1'b0, r_a[s][s*SEG_WIDTH +: SEG_WIDTH]}
                   + {1'b0, r_b[s][s*SEG_WIDTH +: SEG_WIDTH]}
                   + {{SEG_WIDTH{1'b0}}, r_carry[s]};
      w_psum_next[s] = r_psum[s];
      w_psum_next[s][s*SEG_WIDTH +: SEG_WIDTH] = w_seg_add[s][SEG_WIDTH-1:0];
    end
  end

  assign w_result    = w_psum_next[STAGES-1];
  assign w_carry_out = w_seg_add[STAGES-1][SEG_WIDTH];
  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign w_carry_msb = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1] ^ w_result[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_carry     <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_a[s]    <= '0;
        r_b[s]    <= '0;
        r_psum[s] <= '0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_flag_n    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_v    <= 1'b0;
    end else if (w_advance) begin
      r_valid[0] <= bus.in_valid;
      r_psum[0]  <= '0;
      if (bus.in_valid) begin
        r_a[0]     <= bus.a_in;
        r_b[0]     <= w_b_eff;
        r_carry[0] <= bus.sub | bus.c_in;
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_carry[s] <= w_seg_add[s-1][SEG_WIDTH];
        r_a[s]     <= r_a[s-1];
        r_b[s]     <= r_b[s-1];
        r_psum[s]  <= w_psum_next[s-1];
      end
      r_out_valid <= r_valid[STAGES-1];
      // Bubbles leave the last delivered result and flags on the outputs.
      if (r_valid[STAGES-1]) begin
        r_sum    <= w_result;
        r_flag_n <= w_result[WIDTH-1];
        r_flag_z <= (w_result == '0);
        r_flag_c <= w_carry_out;
        r_flag_v <= w_carry_msb ^ w_carry_out;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.flag_n    = r_flag_n;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_v    = r_flag_v;
endmodule
